// File: rtl/tb_memory_mp.sv
// Multi-port, two-bank memory model: address windows, per-bank round-robin
// arbitration with lock, programmable wait states and response latency,
// and error responses for unmapped addresses.
module tb_memory_mp #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned DEPTH     = 16384,
  parameter logic [31:0] B0_BASE   = 32'h00000,
  parameter logic [31:0] B0_LIMIT  = 32'h0ffff,
  parameter logic [31:0] B1_BASE   = 32'h10000,
  parameter logic [31:0] B1_LIMIT  = 32'h1ffff,
  parameter int unsigned WAIT_CYC  = 0,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_PORTS-1:0]      m_req,
  input  logic [NUM_PORTS-1:0]      m_we,
  input  logic [32*NUM_PORTS-1:0]   m_addr,
  input  logic [32*NUM_PORTS-1:0]   m_wdata,
  input  logic [4*NUM_PORTS-1:0]    m_be,
  output logic [NUM_PORTS-1:0]      m_gnt,
  output logic [NUM_PORTS-1:0]      m_rvalid,
  output logic [32*NUM_PORTS-1:0]   m_rdata,
  output logic [NUM_PORTS-1:0]      m_err
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [3:0]  WAIT_L = 4'(WAIT_CYC);

  // Per-port decode; bank 0 has priority where the windows overlap.
  logic [NUM_PORTS-1:0]            hit0;
  logic [NUM_PORTS-1:0]            hit1;
  logic [NUM_PORTS-1:0]            unmapped;
  logic [1:0][NUM_PORTS-1:0]       bank_req;
  logic [1:0][NUM_PORTS-1:0]       bank_gnt;
  logic [1:0][31:0]                bank_dout;

  genvar gi;

  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_decode
    // Unsigned offset compare: addresses below the base wrap to huge offsets.
    assign hit0[gi] = (m_addr[32*gi +: 32] - B0_BASE) <= (B0_LIMIT - B0_BASE);
    assign hit1[gi] = (m_addr[32*gi +: 32] - B1_BASE) <= (B1_LIMIT - B1_BASE);
  end

  assign unmapped    = ~hit0 & ~hit1;
  assign bank_req[0] = m_req & hit0;
  assign bank_req[1] = m_req & ~hit0 & hit1;

  // Unmapped accesses are granted immediately; bank grants come from arbiters.
  // Nothing is granted while reset is held.
  assign m_gnt = (m_req & unmapped & {NUM_PORTS{reset_n}}) | bank_gnt[0] | bank_gnt[1];

  for (gi = 0; gi < 2; gi++) begin : g_bank
    localparam logic [31:0] BASE = (gi == 0) ? B0_BASE : B1_BASE;

    logic [PW-1:0] ptr_reg, ptr_next;
    logic [PW-1:0] owner_reg, owner_next;
    logic          lock_reg, lock_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [PW-1:0] cand, pick, win;
    logic          found, active, grant;
    logic [3:0]    cnt_cur;
    logic [31:0]   sel_addr, sel_wdata, off;
    logic [3:0]    sel_be;
    logic          sel_we;
    logic [AW-1:0] idx;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   dout_reg;

    // Round-robin pick, lock/wait-state tracking and grant decision.
    always_comb begin
      cand       = '0;
      pick       = ptr_reg;
      found      = 1'b0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
        cand = PW'((int'(ptr_reg) + i) % int'(NUM_PORTS));
        if (!found && bank_req[gi][cand]) begin
          pick  = cand;
          found = 1'b1;
        end
      end
      if (lock_reg) begin
        win     = owner_reg;
        active  = bank_req[gi][owner_reg];
        cnt_cur = cnt_reg;
      end else begin
        win     = pick;
        active  = found;
        cnt_cur = 4'd0;
      end
      grant      = active && (cnt_cur == WAIT_L) && reset_n;
      ptr_next   = ptr_reg;
      owner_next = owner_reg;
      lock_next  = 1'b0;
      cnt_next   = 4'd0;
      if (grant) begin
        ptr_next = (win == PW'(NUM_PORTS - 1)) ? '0 : win + PW'(1);
      end else if (active) begin
        lock_next  = 1'b1;
        owner_next = win;
        cnt_next   = cnt_cur + 4'd1;
      end
    end

    // Arbiter state: pointer, lock owner and wait counter.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        ptr_reg   <= '0;
        owner_reg <= '0;
        lock_reg  <= 1'b0;
        cnt_reg   <= 4'd0;
      end else begin
        ptr_reg   <= ptr_next;
        owner_reg <= owner_next;
        lock_reg  <= lock_next;
        cnt_reg   <= cnt_next;
      end
    end

    assign bank_gnt[gi] = grant ? (NUM_PORTS'(1) << win) : '0;
    assign sel_addr     = m_addr[32*win +: 32];
    assign sel_wdata    = m_wdata[32*win +: 32];
    assign sel_be       = m_be[4*win +: 4];
    assign sel_we       = m_we[win];
    assign off          = sel_addr - BASE;
    assign idx          = AW'(off >> 2);
    assign bank_dout[gi] = dout_reg;

    // Bank RAM: registered read of the word as it was before this cycle's write.
    always_ff @(posedge clk) begin
      if (grant) begin
        dout_reg <= mem[idx];
        if (sel_we) begin
          for (int k = 0; k < 4; k++) begin
            if (sel_be[k]) mem[idx][8*k +: 8] <= sel_wdata[8*k +: 8];
          end
        end
      end
    end
  end

  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [RD_LAT-1:0] v_reg;
    logic [RD_LAT-1:0] err_reg;
    logic              rd0_reg;
    logic              bank0_reg;
    logic [31:0]       data0;

    // Response valid/error shift pipeline; stage 0 also remembers the bank and
    // whether a read is pending so the RAM output can be picked up.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v_reg     <= '0;
        err_reg   <= '0;
        rd0_reg   <= 1'b0;
        bank0_reg <= 1'b0;
      end else begin
        v_reg     <= RD_LAT'({v_reg, m_gnt[gi]});
        err_reg   <= RD_LAT'({err_reg, m_gnt[gi] & unmapped[gi]});
        rd0_reg   <= m_gnt[gi] & ~m_we[gi] & ~unmapped[gi];
        bank0_reg <= ~hit0[gi];
      end
    end

    assign data0        = (v_reg[0] && rd0_reg) ? bank_dout[bank0_reg] : 32'h0;
    assign m_rvalid[gi] = v_reg[RD_LAT-1];
    assign m_err[gi]    = v_reg[RD_LAT-1] & err_reg[RD_LAT-1];

    if (RD_LAT == 1) begin : g_lat1
      assign m_rdata[32*gi +: 32] = data0;
    end else begin : g_latn
      logic [31:0] pdata_reg [RD_LAT-1];

      // Carry the captured read word alongside its valid bit.
      always_ff @(posedge clk) begin
        pdata_reg[0] <= data0;
        for (int k = 1; k < int'(RD_LAT) - 1; k++) pdata_reg[k] <= pdata_reg[k-1];
      end

      assign m_rdata[32*gi +: 32] = v_reg[RD_LAT-1] ? pdata_reg[RD_LAT-2] : 32'h0;
    end
  end

endmodule

// File: tb/tb_tb_memory_mp.sv
// Directed bench for tb_memory_mp: three instances cover the default timing,
// wait states with long latency, and pipelining plus mid-flight reset.
module tb_tb_memory_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   = 1'b0;
  logic rst_c_n = 1'b0;

  // dut_a: defaults
  logic [1:0]  a_req = '0, a_we = '0, a_gnt, a_rvalid, a_err;
  logic [63:0] a_addr = '0, a_wdata = '0, a_rdata;
  logic [7:0]  a_be = '0;
  // dut_b: WAIT_CYC=3, RD_LAT=4
  logic [1:0]  b_req = '0, b_we = '0, b_gnt, b_rvalid, b_err;
  logic [63:0] b_addr = '0, b_wdata = '0, b_rdata;
  logic [7:0]  b_be = '0;
  // dut_c: WAIT_CYC=0, RD_LAT=3
  logic [1:0]  c_req = '0, c_we = '0, c_gnt, c_rvalid, c_err;
  logic [63:0] c_addr = '0, c_wdata = '0, c_rdata;
  logic [7:0]  c_be = '0;

  tb_memory_mp dut_a (
    .clk(clk), .reset_n(rst_n), .m_req(a_req), .m_we(a_we), .m_addr(a_addr),
    .m_wdata(a_wdata), .m_be(a_be), .m_gnt(a_gnt), .m_rvalid(a_rvalid),
    .m_rdata(a_rdata), .m_err(a_err)
  );

  tb_memory_mp #(.WAIT_CYC(3), .RD_LAT(4)) dut_b (
    .clk(clk), .reset_n(rst_n), .m_req(b_req), .m_we(b_we), .m_addr(b_addr),
    .m_wdata(b_wdata), .m_be(b_be), .m_gnt(b_gnt), .m_rvalid(b_rvalid),
    .m_rdata(b_rdata), .m_err(b_err)
  );

  tb_memory_mp #(.WAIT_CYC(0), .RD_LAT(3)) dut_c (
    .clk(clk), .reset_n(rst_c_n), .m_req(c_req), .m_we(c_we), .m_addr(c_addr),
    .m_wdata(c_wdata), .m_be(c_be), .m_gnt(c_gnt), .m_rvalid(c_rvalid),
    .m_rdata(c_rdata), .m_err(c_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  // One single-port transaction on dut_a: gnt same cycle, response one cycle later.
  task automatic txn_a(input int idx, input vec_t v);
    string nm;
    nm = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    a_req[v.port]            = 1'b1;
    a_we[v.port]             = v.we;
    a_addr[32*v.port +: 32]  = v.addr;
    a_wdata[32*v.port +: 32] = v.wdata;
    a_be[4*v.port +: 4]      = v.be;
    @(negedge clk);
    chk({nm, "_gnt"}, 32'(a_gnt[v.port]), 32'd1);
    @(posedge clk); #1;
    a_req[v.port] = 1'b0;
    @(negedge clk);
    chk({nm, "_rvalid"}, 32'(a_rvalid[v.port]), 32'd1);
    chk({nm, "_rdata"}, a_rdata[32*v.port +: 32], v.exp_rdata);
    chk({nm, "_err"}, 32'(a_err[v.port]), 32'(v.exp_err));
    $display("txn %s port %0d %s addr=%08h rdata=%08h err=%0b", nm, v.port,
             v.we ? "WR" : "RD", v.addr, a_rdata[32*v.port +: 32], a_err[v.port]);
  endtask

  // One port-0 transaction on dut_b, measuring wait-state and latency cycles.
  task automatic txn_b(input string nm, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_d);
    int   waited;
    int   lat;
    logic got;
    logic [31:0] rd;
    @(posedge clk); #1;
    b_req[0] = 1'b1; b_we[0] = we; b_addr[31:0] = addr; b_wdata[31:0] = wdata; b_be[3:0] = 4'hf;
    waited = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (b_gnt[0]) got = 1'b1; else waited++;
    end
    chk({nm, "_gnt_wait"}, 32'(waited), 32'd3);
    @(posedge clk); #1;
    b_req[0] = 1'b0;
    lat = 1; got = 1'b0; rd = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (b_rvalid[0]) begin got = 1'b1; rd = b_rdata[31:0]; end
      else lat++;
    end
    chk({nm, "_lat"}, 32'(lat), 32'd4);
    chk({nm, "_rdata"}, rd, exp_d);
    $display("txn %s addr=%08h wait=%0d lat=%0d rdata=%08h", nm, addr, waited, lat, rd);
  endtask

  logic [31:0] words [4];
  logic        rv_s [8];
  logic [31:0] rd_s [8];
  int          cnt;

  initial begin
    vecs[0]  = '{0, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'hf, 32'h0,          1'b0};
    vecs[1]  = '{0, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
    vecs[2]  = '{1, 1'b1, 32'h0001_0008, 32'h0,         4'hf, 32'h0,          1'b0};
    vecs[3]  = '{1, 1'b1, 32'h0001_0008, 32'hAABB_CCDD, 4'h5, 32'h0,          1'b0};
    vecs[4]  = '{0, 1'b0, 32'h0001_0008, 32'h0,         4'h0, 32'h00BB_00DD, 1'b0};
    vecs[5]  = '{1, 1'b1, 32'h0001_0000, 32'h1111_2222, 4'hf, 32'h0,          1'b0};
    vecs[6]  = '{0, 1'b1, 32'h0000_fffc, 32'h3333_4444, 4'hf, 32'h0,          1'b0};
    vecs[7]  = '{1, 1'b1, 32'h0001_fffc, 32'h5555_6666, 4'hf, 32'h0,          1'b0};
    vecs[8]  = '{0, 1'b0, 32'h0002_0000, 32'h0,         4'h0, 32'h0,          1'b1};
    vecs[9]  = '{0, 1'b1, 32'h0002_0000, 32'hDEAD_BEEF, 4'hf, 32'h0,          1'b1};
    vecs[10] = '{1, 1'b1, 32'hFFFF_FFFC, 32'hCAFE_BABE, 4'hf, 32'h0,          1'b1};
    vecs[11] = '{0, 1'b0, 32'h0000_fffc, 32'h0,         4'h0, 32'h3333_4444, 1'b0};
    vecs[12] = '{0, 1'b0, 32'h0001_fffc, 32'h0,         4'h0, 32'h5555_6666, 1'b0};
    vecs[13] = '{0, 1'b0, 32'h0001_0000, 32'h0,         4'h0, 32'h1111_2222, 1'b0};
    vecs[14] = '{1, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h1234_5678, 1'b0};

    // Reset with a pending request: nothing may be granted.
    a_req = 2'b01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(a_gnt), 32'd0);
    chk("rst_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_rdata", a_rdata[31:0], 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    @(posedge clk); #1;
    a_req = 2'b00;
    rst_n = 1'b1; rst_c_n = 1'b1;

    for (int i = 0; i < 15; i++) txn_a(i, vecs[i]);

    // Two ports hammering IRAM: grants must alternate starting at port 0.
    @(posedge clk); #1;
    a_req = 2'b11; a_we = 2'b00; a_addr = {32'h0000_0044, 32'h0000_0040};
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk($sformatf("rr_gnt%0d", j), 32'(a_gnt), (j % 2 == 0) ? 32'd1 : 32'd2);
      $display("txn rr cycle %0d gnt=%02b", j, a_gnt);
      @(posedge clk); #1;
    end
    a_req = 2'b00;
    repeat (2) @(posedge clk);
    #1;

    // IRAM and DRAM in the same cycle: both granted together.
    a_req = 2'b11; a_addr = {32'h0001_0008, 32'h0000_0040};
    @(negedge clk);
    chk("dual_gnt", 32'(a_gnt), 32'd3);
    @(posedge clk); #1;
    a_req = 2'b00;
    @(negedge clk);
    chk("dual_rvalid", 32'(a_rvalid), 32'd3);
    chk("dual_rdata0", a_rdata[31:0], 32'h1234_5678);
    chk("dual_rdata1", a_rdata[63:32], 32'h00BB_00DD);
    $display("txn dual gnt both rdata0=%08h rdata1=%08h", a_rdata[31:0], a_rdata[63:32]);

    // Wait states and long latency.
    txn_b("b_wr", 1'b1, 32'h0000_0040, 32'hA5A5_0001, 32'h0);
    txn_b("b_rd", 1'b0, 32'h0000_0040, 32'h0,         32'hA5A5_0001);

    // Back-to-back writes then reads on one port of dut_c.
    words[0] = 32'h0101_0101; words[1] = 32'h0202_0202;
    words[2] = 32'h0303_0303; words[3] = 32'h0404_0404;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      c_req[0] = 1'b1; c_we[0] = 1'b1; c_be[3:0] = 4'hf;
      c_addr[31:0] = 32'h100 + 32'(4 * j); c_wdata[31:0] = words[j];
    end
    @(posedge clk); #1;
    c_req = 2'b00; c_we = 2'b00;
    repeat (4) @(posedge clk);
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      if (j < 4) begin
        c_req[0] = 1'b1; c_addr[31:0] = 32'h100 + 32'(4 * j);
      end else begin
        c_req[0] = 1'b0;
      end
      @(negedge clk);
      rv_s[j] = c_rvalid[0];
      rd_s[j] = c_rdata[31:0];
    end
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("b2b_rvalid%0d", j), 32'(rv_s[j]), (j >= 3 && j <= 6) ? 32'd1 : 32'd0);
      if (j >= 3 && j <= 6) chk($sformatf("b2b_rdata%0d", j), rd_s[j], words[j-3]);
      $display("txn b2b cycle %0d rvalid=%0b rdata=%08h", j, rv_s[j], rd_s[j]);
    end

    // Reset with two reads in flight and a third request pending.
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      c_req[0] = 1'b1; c_addr[31:0] = 32'h100 + 32'(4 * j);
    end
    @(posedge clk); #1;
    c_addr[31:0] = 32'h108;
    rst_c_n = 1'b0;
    @(negedge clk);
    chk("mrst_gnt", 32'(c_gnt), 32'd0);
    chk("mrst_rvalid", 32'(c_rvalid), 32'd0);
    chk("mrst_rdata", c_rdata[31:0], 32'd0);
    chk("mrst_err", 32'(c_err), 32'd0);
    @(posedge clk); #1;
    c_req = 2'b00;
    @(posedge clk); #1;
    rst_c_n = 1'b1;
    cnt = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (c_rvalid != 2'b00) cnt++;
    end
    chk("mrst_no_rvalid", 32'(cnt), 32'd0);
    $display("txn reset-release stray rvalids=%0d", cnt);
    @(posedge clk); #1;
    c_req = 2'b11; c_we = 2'b00; c_addr = {32'h0000_0104, 32'h0000_0100};
    @(negedge clk);
    chk("post_rst_gnt", 32'(c_gnt), 32'd1);
    @(posedge clk); #1;
    c_req = 2'b10;
    @(negedge clk);
    chk("post_rst_gnt2", 32'(c_gnt), 32'd2);
    @(posedge clk); #1;
    c_req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_rvalid", 32'(c_rvalid), 32'd1);
    chk("post_rst_rdata", c_rdata[31:0], words[0]);
    $display("txn post-reset port0 rdata=%08h", c_rdata[31:0]);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
